// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] PC_INC            = 32'd4;
  // addi x0,x0,0: the bubble presented to IF/ID when nothing valid is fetched.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side signal bundle: PC register, instruction memory, hazard/redirect and IF/ID.
interface fetch_ctrl_if;

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ifid_en;
  logic        ifid_flush;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;

  // The fetch controller side.
  modport master (
    input  pc_q,
    output pc_next,
    output pc_en,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  stall_id,
    input  redirect_valid,
    input  redirect_target,
    output ifid_en,
    output ifid_flush,
    output ifid_instr,
    output ifid_pc
  );

  // The surrounding pipeline: PC register, memory, hazard unit, IF/ID register.
  modport slave (
    output pc_q,
    input  pc_next,
    input  pc_en,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output stall_id,
    output redirect_valid,
    output redirect_target,
    input  ifid_en,
    input  ifid_flush,
    input  ifid_instr,
    input  ifid_pc
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, a one-entry skid for load-use
// stalls, and flush handling for EX-stage redirects. The PC register itself
// lives outside and is driven through pc_next/pc_en.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic         redirect;

  // The fetch address is always the live PC register value.
  assign bus.imem_addr = bus.pc_q;

  // A redirect only counts once the boot vector has been loaded.
  assign redirect = bus.redirect_valid && (state_q != IDLE);

  // Next-state, register updates and all combinational outputs.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    skid_d         = skid_q;
    skid_pc_d      = skid_pc_q;
    bus.pc_en      = 1'b0;
    bus.pc_next    = bus.pc_q + PC_INC;
    bus.imem_req   = 1'b0;
    bus.ifid_en    = 1'b0;
    bus.ifid_flush = 1'b0;
    bus.ifid_instr = NOP_INSTR;
    bus.ifid_pc    = fetch_pc_q;

    case (state_q)
      IDLE: begin
        bus.pc_en   = 1'b1;
        bus.pc_next = RESET_PC;
        state_d     = REQ;
      end

      REQ: begin
        // Responses arriving here are leftovers from before a reset; ignore them.
        if (!redirect) begin
          bus.imem_req = 1'b1;
          if (bus.imem_gnt) begin
            // The PC advances at grant, regardless of any downstream stall.
            fetch_pc_d  = bus.pc_q;
            bus.pc_en   = 1'b1;
            bus.pc_next = bus.pc_q + PC_INC;
            state_d     = WAIT;
          end
        end
      end

      WAIT: begin
        if (redirect) begin
          // Response in the same cycle is simply dropped; otherwise it is still
          // in flight and must be swallowed in DRAIN.
          state_d = bus.imem_rvalid ? REQ : DRAIN;
        end else if (bus.imem_rvalid) begin
          if (bus.stall_id) begin
            skid_d    = bus.imem_rdata;
            skid_pc_d = fetch_pc_q;
            state_d   = HOLD;
          end else begin
            bus.ifid_en    = 1'b1;
            bus.ifid_instr = bus.imem_rdata;
            bus.ifid_pc    = fetch_pc_q;
            state_d        = REQ;
          end
        end
      end

      DRAIN: begin
        // A redirect that coincides with the stale response leaves nothing in
        // flight, so fetching can restart; otherwise keep waiting for it.
        if (bus.imem_rvalid) begin
          state_d = REQ;
        end
      end

      HOLD: begin
        bus.ifid_instr = skid_q;
        bus.ifid_pc    = skid_pc_q;
        if (redirect) begin
          skid_d    = NOP_INSTR;
          skid_pc_d = 32'd0;
          state_d   = REQ;
        end else if (!bus.stall_id) begin
          bus.ifid_en = 1'b1;
          state_d     = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect wins over stall and grant: reload the PC and bubble IF/ID.
    if (redirect) begin
      bus.pc_en      = 1'b1;
      bus.pc_next    = bus.redirect_target;
      bus.ifid_flush = 1'b1;
      bus.ifid_en    = 1'b0;
      bus.imem_req   = 1'b0;
    end

    // Keep every enable quiet while reset is held.
    if (rst) begin
      bus.pc_en      = 1'b0;
      bus.imem_req   = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.ifid_instr = NOP_INSTR;
      bus.ifid_pc    = 32'd0;
    end
  end

  // State and skid registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= 32'd0;
      skid_q     <= NOP_INSTR;
      skid_pc_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and single-response memory model around
// the DUT, with a queue of expected IF/ID deliveries checked on every ifid_en.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  fetch_ctrl_if bus ();

  exp_t        exp_q[$];
  exp_t        e;
  int          n_checks;
  int          n_fail;
  logic        pend;
  logic [31:0] pend_addr;
  logic        rsp_hold;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.pc_q <= 32'd0;
    else if (bus.pc_en) bus.pc_q <= bus.pc_next;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mid-cycle: score IF/ID deliveries and record memory grants.
  task automatic sample();
    @(negedge clk);
    if (bus.ifid_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_ifid_en", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_ifid_pc", bus.ifid_pc, e.pc);
        check_eq("sb_ifid_instr", bus.ifid_instr, e.instr);
      end
    end
    if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
      pend      = 1'b1;
      pend_addr = bus.imem_addr;
      exp_q.push_back('{pc: bus.imem_addr, instr: bus.imem_addr ^ KEY});
    end
  endtask

  // Just after the clock edge: present the memory response for this cycle.
  task automatic adv();
    @(posedge clk);
    #1;
    if (pend && !rsp_hold) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = pend_addr ^ KEY;
      pend            = 1'b0;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
    end
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pend     = 1'b0;
    pend_addr = 32'd0;
    rsp_hold = 1'b0;
    rst = 1'b1;
    bus.imem_gnt        = 1'b0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = 32'd0;
    bus.stall_id        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;

    // Reset values.
    sample();
    check_eq("rst_pc_en", bus.pc_en, 32'd0);
    check_eq("rst_imem_req", bus.imem_req, 32'd0);
    check_eq("rst_ifid_en", bus.ifid_en, 32'd0);
    check_eq("rst_ifid_flush", bus.ifid_flush, 32'd0);
    check_eq("rst_ifid_instr", bus.ifid_instr, NOP);
    check_eq("rst_ifid_pc", bus.ifid_pc, 32'd0);
    check_eq("rst_pc_next", bus.pc_next, 32'd0);
    adv();
    cyc();
    rst = 1'b0;
    bus.imem_gnt = 1'b1;

    // Boot: first cycle loads the reset vector.
    sample();
    check_eq("boot_pc_en", bus.pc_en, 32'd1);
    check_eq("boot_pc_next", bus.pc_next, 32'd0);
    check_eq("boot_imem_req", bus.imem_req, 32'd0);
    adv();
    for (int k = 0; k < 4; k++) begin
      sample();
      check_eq("boot_req", bus.imem_req, 32'd1);
      check_eq("boot_addr", bus.imem_addr, 32'(k * 4));
      check_eq("boot_pc_next_inc", bus.pc_next, 32'(k * 4 + 4));
      adv();
      sample();
      check_eq("boot_ifid_en", bus.ifid_en, 32'd1);
      check_eq("boot_wait_req", bus.imem_req, 32'd0);
      adv();
    end

    // Grant latency at 0x10.
    bus.imem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq("gnt_req_held", bus.imem_req, 32'd1);
      check_eq("gnt_addr_held", bus.imem_addr, 32'h10);
      check_eq("gnt_pc_en_low", bus.pc_en, 32'd0);
      adv();
    end
    bus.imem_gnt = 1'b1;
    sample();
    check_eq("gnt_pc_en", bus.pc_en, 32'd1);
    check_eq("gnt_pc_next", bus.pc_next, 32'h14);
    adv();
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      cyc();
    end

    // Load-use stall on the 0x20 response.
    sample();
    check_eq("lu_addr", bus.imem_addr, 32'h20);
    adv();
    bus.stall_id = 1'b1;
    sample();
    check_eq("lu_wait_ifid_en", bus.ifid_en, 32'd0);
    adv();
    sample();
    check_eq("lu_hold_ifid_en", bus.ifid_en, 32'd0);
    check_eq("lu_hold_instr", bus.ifid_instr, 32'h20 ^ KEY);
    check_eq("lu_hold_pc", bus.ifid_pc, 32'h20);
    check_eq("lu_hold_req", bus.imem_req, 32'd0);
    adv();
    bus.stall_id = 1'b0;
    sample();
    check_eq("lu_release_ifid_en", bus.ifid_en, 32'd1);
    check_eq("lu_queue_empty", 32'(exp_q.size()), 32'd0);
    adv();

    // Redirect in WAIT before the response arrives.
    rsp_hold = 1'b1;
    sample();
    check_eq("rdw_addr", bus.imem_addr, 32'h24);
    adv();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    sample();
    check_eq("rdw_pc_en", bus.pc_en, 32'd1);
    check_eq("rdw_pc_next", bus.pc_next, 32'h100);
    check_eq("rdw_flush", bus.ifid_flush, 32'd1);
    check_eq("rdw_ifid_en", bus.ifid_en, 32'd0);
    void'(exp_q.pop_back());
    rsp_hold = 1'b0;
    adv();
    bus.redirect_valid = 1'b0;
    sample();
    check_eq("rdw_drain_ifid_en", bus.ifid_en, 32'd0);
    check_eq("rdw_drain_req", bus.imem_req, 32'd0);
    adv();
    sample();
    check_eq("rdw_refetch_req", bus.imem_req, 32'd1);
    check_eq("rdw_refetch_addr", bus.imem_addr, 32'h100);
    adv();

    // Redirect coincident with a stalled response: flush wins.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    bus.stall_id        = 1'b1;
    sample();
    check_eq("rdc_flush", bus.ifid_flush, 32'd1);
    check_eq("rdc_ifid_en", bus.ifid_en, 32'd0);
    check_eq("rdc_pc_next", bus.pc_next, 32'h200);
    void'(exp_q.pop_back());
    adv();
    bus.redirect_valid = 1'b0;
    bus.stall_id       = 1'b0;
    sample();
    check_eq("rdc_req", bus.imem_req, 32'd1);
    check_eq("rdc_addr", bus.imem_addr, 32'h200);
    adv();
    sample();
    check_eq("rdc_ifid_en", bus.ifid_en, 32'd1);
    adv();

    // Redirect from REQ to the top of the address space, then wrap.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    sample();
    check_eq("wrap_redirect_req", bus.imem_req, 32'd0);
    check_eq("wrap_redirect_pc_next", bus.pc_next, 32'hFFFF_FFFC);
    adv();
    bus.redirect_valid = 1'b0;
    rsp_hold = 1'b1;
    sample();
    check_eq("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_pc_en", bus.pc_en, 32'd1);
    check_eq("wrap_pc_next", bus.pc_next, 32'h0000_0000);
    adv();

    // Asynchronous reset mid-WAIT.
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_pc_en", bus.pc_en, 32'd0);
    check_eq("arst_req", bus.imem_req, 32'd0);
    check_eq("arst_ifid_en", bus.ifid_en, 32'd0);
    check_eq("arst_flush", bus.ifid_flush, 32'd0);
    check_eq("arst_instr", bus.ifid_instr, NOP);
    check_eq("arst_ifid_pc", bus.ifid_pc, 32'd0);
    check_eq("arst_pc_next", bus.pc_next, 32'd0);
    void'(exp_q.pop_back());
    pend = 1'b0;
    rsp_hold = 1'b0;
    cyc();
    rst = 1'b0;
    // Late response from the aborted fetch lands in IDLE.
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    sample();
    check_eq("late_ifid_en", bus.ifid_en, 32'd0);
    check_eq("late_pc_en", bus.pc_en, 32'd1);
    check_eq("late_pc_next", bus.pc_next, 32'd0);
    adv();
    sample();
    check_eq("refetch_addr", bus.imem_addr, 32'd0);
    check_eq("refetch_ifid_en", bus.ifid_en, 32'd0);
    adv();
    sample();
    check_eq("refetch_deliver", bus.ifid_en, 32'd1);
    adv();
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the PC register and instruction-memory fetch for the pipelined RV32I core, one outstanding request at a time.
- Drives the PC register's enable and next value, and the imem req/gnt/rvalid handshake.
- Fills the IF/ID register, absorbing load-use stalls from the hazard unit and EX-stage branch/jump redirects.

Parameters:
- RESET_PC, 32'h0000_0000, boot vector loaded into the PC on the first cycle after reset.
- NOP_INSTR, 32'h0000_0013, value of ifid_instr when no valid instruction is presented (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pc_q  in  32  current PC register value.
- pc_next  out  32  next PC value; the PC register loads it when pc_en=1.
- pc_en  out  1  PC register load enable.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc_q.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- stall_id  in  1  load-use stall from the hazard unit; IF/ID must hold.
- redirect_valid  in  1  taken branch/jump resolved in EX.
- redirect_target  in  32  redirect PC, word aligned.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear (insert bubble).
- ifid_instr  out  32  instruction to IF/ID.
- ifid_pc  out  32  PC of ifid_instr.

Behaviour:
- Reset: async, active-high. Sets state=IDLE, fetch_pc=0, skid=NOP_INSTR, skid_pc=0.
- During reset all outputs are 0, except ifid_instr=NOP_INSTR, and pc_next/imem_addr, which follow their combinational definitions.
- All outputs are combinational from state, registers and inputs. Defaults: pc_en=0, imem_req=0, ifid_en=0, ifid_flush=0, ifid_instr=NOP_INSTR, ifid_pc=fetch_pc.
- Redirect rule, all states except IDLE: redirect_valid forces pc_en=1, pc_next=redirect_target, ifid_flush=1, ifid_en=0, imem_req=0. Redirect overrides stall_id and gnt.
- IDLE: pc_en=1, pc_next=RESET_PC, redirect ignored. Next state is REQ.
- REQ: imem_req=1, imem_addr=pc_q.
  - On gnt: fetch_pc<=pc_q; pc_en=1, pc_next=pc_q+4 (mod 2^32, wraps to 0); go to WAIT.
  - Without gnt: hold.
  - Stray rvalid in REQ is ignored.
- WAIT, on rvalid without stall: ifid_en=1, ifid_instr=imem_rdata, ifid_pc=fetch_pc; go to REQ.
- WAIT, on rvalid with stall_id=1: skid<=imem_rdata, skid_pc<=fetch_pc; go to HOLD.
- WAIT, on redirect: if rvalid arrives the same cycle, drop the response and go to REQ; otherwise go to DRAIN.
- DRAIN: discard the next rvalid, then go to REQ. A further redirect reloads the PC and stays in DRAIN.
- HOLD: ifid_instr=skid, ifid_pc=skid_pc.
  - While stall_id=1: ifid_en=0, stay.
  - When stall_id=0: ifid_en=1, go to REQ.
  - On redirect: drop skid, go to REQ.
- PC advances at grant, independent of stall_id. Throughput is 1 instruction per 2 cycles when gnt is immediate and rvalid arrives the next cycle.
- Exactly one fetch is outstanding; imem_req=0 in WAIT, DRAIN and HOLD.
- Reset mid-fetch: any in-flight response after reset release is ignored (arrives in IDLE/REQ).

Decomposition:
- fetch_pkg holds:
  - typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} fetch_state_t;
  - localparam PC_INC=32'd4;
  - localparam NOP_INSTR default value.
- No sub-module. Skid register and FSM are inline; the PC register stays a separate instance driven by pc_next/pc_en.

Test Plan:
- Boot: release rst, gnt=1 always, rvalid one cycle after gnt, rdata=addr^32'hA5A5_0000.
  - Cycle 1: pc_en=1, pc_next=0.
  - Then imem_addr = 0, 4, 8 on alternating cycles.
  - ifid_pc = 0, 4, 8, each with matching ifid_instr.
- Grant latency: gnt held low 3 cycles in REQ at pc_q=0x10 → imem_req stays 1, addr stays 0x10, pc_en=0 until gnt; then pc_next=0x14.
- Load-use: stall_id=1 for 2 cycles, asserted when rvalid arrives for 0x20 → HOLD.
  - ifid_en=0 for 2 cycles; ifid_instr holds the 0x20 word.
  - ifid_en=1 when stall drops; no instruction lost or duplicated.
- Redirect in WAIT before rvalid (target 0x100) → pc_en=1, pc_next=0x100, ifid_flush=1.
  - The next rvalid is discarded (ifid_en=0).
  - The following request is imem_addr=0x100.
- Redirect coincident with rvalid and stall_id=1 → flush wins; response dropped, no HOLD entry, next imem_addr=target.
- Wrap and reset: pc_q=0xFFFF_FFFC granted → pc_next=0x0000_0000.
  - Assert rst asynchronously mid-WAIT → state IDLE immediately, outputs at reset values.
  - Late rvalid after release is ignored; refetch starts at RESET_PC.
